mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/mem_arbiter_pick2.sv | 11 +
 rtl/mem_arbiter.sv | 63 ++++++
 tb/tb_mem_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: arbiter FSM states and master indices shared across the mem_arbiter slice.
package mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam logic M_IFETCH = 1'b0;
  localparam logic M_DATA   = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arb_if: one memory request port; master drives requests, slave returns data and ready.
interface mem_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  read_enable;
  logic                  write_enable;
  logic                  mem_signed_read;
  logic [1:0]            mem_data_width;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  mem_ready;
  modport master (
    output read_enable, write_enable, mem_signed_read, mem_data_width, address, data_in,
    input  data_out, mem_ready
  );
  modport slave (
    input  read_enable, write_enable, mem_signed_read, mem_data_width, address, data_in,
    output data_out, mem_ready
  );
endinterface

// File: rtl/mem_arbiter_pick2.sv
// arb_pick2: combinational winner select between two requesters, round-robin or fixed priority.
module arb_pick2 #(
  parameter bit PRIO_MASTER = 1'b1
) (
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  input  logic       i_rr_en,
  output logic       o_winner
);
  always_comb o_winner = (i_req == 2'b11) ? (i_rr_en ? ~i_rr_last : PRIO_MASTER) : i_req[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single mmu port to one of two masters per transaction.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise PRIO_MASTER always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter bit PRIO_MASTER = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  mem_arb_if.slave   m0,
  mem_arb_if.slave   m1,
  mem_arb_if.master  mmu,
  output logic       grant,
  output logic       busy
);
  state_e     r_state, w_next;
  logic       r_grant, w_winner, w_rr_last, w_rr_en, w_busy, w_done;
  logic [1:0] w_req;
  assign w_req  = {m1.read_enable | m1.write_enable, m0.read_enable | m0.write_enable};
  assign w_busy = reset_n && r_state == BUSY;
  assign w_done = w_busy && mmu.mem_ready;
`ifdef MEM_ARB_RR_EN
  logic r_rr_last;
  always_ff @(posedge clk)
    if (!reset_n) r_rr_last <= 1'b1;
    else if (w_done) r_rr_last <= r_grant;
  assign w_rr_last = r_rr_last;
  assign w_rr_en   = 1'b1;
`else
  assign w_rr_last = 1'b0;
  assign w_rr_en   = 1'b0;
`endif
  arb_pick2 #(.PRIO_MASTER(PRIO_MASTER)) u_pick (
    .i_req(w_req), .i_rr_last(w_rr_last), .i_rr_en(w_rr_en), .o_winner(w_winner)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= M_IFETCH;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_req) r_grant <= w_winner;
    end
  always_comb w_next = (r_state == IDLE) ? (|w_req ? BUSY : IDLE) : (mmu.mem_ready ? IDLE : BUSY);
  // A master raising both enables gets a write; the read is suppressed.
  always_comb begin
    mmu.write_enable    = w_busy & (r_grant ? m1.write_enable : m0.write_enable);
    mmu.read_enable     = w_busy & (r_grant ? m1.read_enable : m0.read_enable)
                        & ~(r_grant ? m1.write_enable : m0.write_enable);
    mmu.mem_signed_read = w_busy & (r_grant ? m1.mem_signed_read : m0.mem_signed_read);
    mmu.mem_data_width  = w_busy ? (r_grant ? m1.mem_data_width : m0.mem_data_width) : 2'b00;
    mmu.address         = w_busy ? (r_grant ? m1.address : m0.address) : '0;
    mmu.data_in         = w_busy ? (r_grant ? m1.data_in : m0.data_in) : '0;
  end
  assign m0.mem_ready = w_done && r_grant == M_IFETCH;
  assign m1.mem_ready = w_done && r_grant == M_DATA;
  assign m0.data_out  = m0.mem_ready ? mmu.data_out : '0;
  assign m1.data_out  = m1.mem_ready ? mmu.data_out : '0;
  assign grant = r_grant;
  assign busy  = w_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tasks for mem_arbiter; inputs change on negedge, outputs read 1ns later.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic grant, busy;
  int   checks = 0;
  int   errors = 0;
  mem_arb_if #(32, 32) m0 ();
  mem_arb_if #(32, 32) m1 ();
  mem_arb_if #(32, 32) mmu ();
  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIO_MASTER(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0), .m1(m1), .mmu(mmu), .grant(grant), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end
  task automatic clear_inputs();
    m0.read_enable = 0; m0.write_enable = 0; m0.mem_signed_read = 0; m0.mem_data_width = 2'b01;
    m0.address = '0; m0.data_in = '0;
    m1.read_enable = 0; m1.write_enable = 0; m1.mem_signed_read = 0; m1.mem_data_width = 2'b11;
    m1.address = '0; m1.data_in = '0;
    mmu.mem_ready = 0; mmu.data_out = '0;
  endtask
  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    m0.read_enable = 1; mmu.mem_ready = 1; mmu.data_out = 32'h1234;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", busy); end
    checks++; if (mmu.read_enable !== 1'b0) begin errors++; $display("FAIL rst_mmu_rd got %0h exp 0", mmu.read_enable); end
    checks++; if (m0.mem_ready !== 1'b0 || m0.data_out !== 32'h0) begin errors++; $display("FAIL rst_m0_out got %0h/%h exp 0/0", m0.mem_ready, m0.data_out); end
    @(negedge clk);
    clear_inputs();
    reset_n = 1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %0h exp 0", busy); end
  endtask
  task automatic test_single_read();
    @(negedge clk);
    m0.read_enable = 1; m0.address = 32'h100; #1;
    checks++; if (mmu.read_enable !== 1'b0) begin errors++; $display("FAIL rd_idle_mmu got %0h exp 0", mmu.read_enable); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1 || grant !== 1'b0) begin errors++; $display("FAIL rd_grant got busy=%0h grant=%0h exp 1/0", busy, grant); end
    checks++; if (mmu.read_enable !== 1'b1 || mmu.address !== 32'h100) begin errors++; $display("FAIL rd_fwd got %0h/%h exp 1/100", mmu.read_enable, mmu.address); end
    @(negedge clk); #1;
    checks++; if (m0.mem_ready !== 1'b0) begin errors++; $display("FAIL rd_early_ready got %0h exp 0", m0.mem_ready); end
    @(negedge clk);
    mmu.mem_ready = 1; mmu.data_out = 32'hDEADBEEF; #1;
    checks++; if (m0.mem_ready !== 1'b1 || m0.data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_done got %0h/%h exp 1/deadbeef", m0.mem_ready, m0.data_out); end
    checks++; if (m1.mem_ready !== 1'b0 || m1.data_out !== 32'h0) begin errors++; $display("FAIL rd_m1_quiet got %0h/%h exp 0/0", m1.mem_ready, m1.data_out); end
    @(negedge clk);
    m0.read_enable = 0; mmu.mem_ready = 0; #1;
    checks++; if (busy !== 1'b0 || m0.mem_ready !== 1'b0) begin errors++; $display("FAIL rd_after got %0h/%0h exp 0/0", busy, m0.mem_ready); end
  endtask
  task automatic test_contention();
    logic exp;
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1; m0.read_enable = 1; m1.read_enable = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp = 1'(i % 2);
`else
      exp = 1'b1;
`endif
      @(negedge clk); #1;
      checks++; if (busy !== 1'b1 || grant !== exp) begin errors++; $display("FAIL cont_grant%0d got busy=%0h grant=%0h exp 1/%0h", i, busy, grant, exp); end
      mmu.mem_ready = 1; mmu.data_out = 32'hA0 + i; #1;
      checks++; if ((exp ? m1.mem_ready : m0.mem_ready) !== 1'b1 || (exp ? m0.mem_ready : m1.mem_ready) !== 1'b0) begin errors++; $display("FAIL cont_ready%0d got m0=%0h m1=%0h exp winner %0h", i, m0.mem_ready, m1.mem_ready, exp); end
      checks++; if ((exp ? m1.data_out : m0.data_out) !== 32'hA0 + i) begin errors++; $display("FAIL cont_data%0d got %h exp %h", i, exp ? m1.data_out : m0.data_out, 32'hA0 + i); end
      @(negedge clk);
      mmu.mem_ready = 0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_gap%0d got %0h exp 0", i, busy); end
    end
    m0.read_enable = 0; m1.read_enable = 0;
  endtask
  task automatic test_queued_write();
    @(negedge clk);
    m0.read_enable = 1; m0.address = 32'h300;
    @(negedge clk);
    m1.write_enable = 1; m1.address = 32'h2000; m1.data_in = 32'hCAFEF00D; #1;
    checks++; if (mmu.write_enable !== 1'b0 || mmu.address !== 32'h300) begin errors++; $display("FAIL q_hold got %0h/%h exp 0/300", mmu.write_enable, mmu.address); end
    @(negedge clk);
    mmu.mem_ready = 1; #1;
    checks++; if (m0.mem_ready !== 1'b1 || m1.mem_ready !== 1'b0) begin errors++; $display("FAIL q_m0_done got %0h/%0h exp 1/0", m0.mem_ready, m1.mem_ready); end
    @(negedge clk);
    m0.read_enable = 0; mmu.mem_ready = 0; #1;
    checks++; if (busy !== 1'b0 || mmu.write_enable !== 1'b0) begin errors++; $display("FAIL q_gap got %0h/%0h exp 0/0", busy, mmu.write_enable); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1 || grant !== 1'b1) begin errors++; $display("FAIL q_grant got %0h/%0h exp 1/1", busy, grant); end
    checks++; if (mmu.write_enable !== 1'b1 || mmu.read_enable !== 1'b0) begin errors++; $display("FAIL q_wr got %0h/%0h exp 1/0", mmu.write_enable, mmu.read_enable); end
    checks++; if (mmu.address !== 32'h2000 || mmu.data_in !== 32'hCAFEF00D) begin errors++; $display("FAIL q_bus got %h/%h exp 2000/cafef00d", mmu.address, mmu.data_in); end
    checks++; if (mmu.mem_data_width !== 2'b11) begin errors++; $display("FAIL q_width got %0h exp 3", mmu.mem_data_width); end
    mmu.mem_ready = 1; #1;
    checks++; if (m1.mem_ready !== 1'b1 || m0.mem_ready !== 1'b0) begin errors++; $display("FAIL q_m1_done got %0h/%0h exp 1/0", m1.mem_ready, m0.mem_ready); end
    @(negedge clk);
    m1.write_enable = 0; mmu.mem_ready = 0;
  endtask
  task automatic test_reset_busy();
    @(negedge clk);
    m0.read_enable = 1; m0.address = 32'h400;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rb_busy got %0h exp 1", busy); end
    reset_n = 0; #1;
    checks++; if (busy !== 1'b0 || mmu.read_enable !== 1'b0) begin errors++; $display("FAIL rb_hold got %0h/%0h exp 0/0", busy, mmu.read_enable); end
    @(negedge clk);
    reset_n = 1; m0.read_enable = 0; mmu.mem_ready = 1; mmu.data_out = 32'h55; #1;
    checks++; if (busy !== 1'b0 || mmu.read_enable !== 1'b0 || mmu.write_enable !== 1'b0) begin errors++; $display("FAIL rb_after got %0h/%0h/%0h exp 0/0/0", busy, mmu.read_enable, mmu.write_enable); end
    checks++; if (m0.mem_ready !== 1'b0 || m1.mem_ready !== 1'b0) begin errors++; $display("FAIL rb_late got %0h/%0h exp 0/0", m0.mem_ready, m1.mem_ready); end
    @(negedge clk);
    mmu.mem_ready = 0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rb_idle got %0h exp 0", busy); end
  endtask
  task automatic test_both_enables();
    @(negedge clk);
    m0.read_enable = 1; m0.write_enable = 1; m0.address = 32'h500; m0.data_in = 32'h77;
    @(negedge clk); #1;
    checks++; if (mmu.write_enable !== 1'b1 || mmu.read_enable !== 1'b0) begin errors++; $display("FAIL both_en got wr=%0h rd=%0h exp 1/0", mmu.write_enable, mmu.read_enable); end
    mmu.mem_ready = 1; #1;
    checks++; if (m0.mem_ready !== 1'b1) begin errors++; $display("FAIL both_done got %0h exp 1", m0.mem_ready); end
    @(negedge clk);
    m0.read_enable = 0; m0.write_enable = 0; mmu.mem_ready = 0;
  endtask
  task automatic test_width_signed();
    @(negedge clk);
    m1.read_enable = 1; m1.mem_data_width = 2'b00; m1.mem_signed_read = 1; m1.address = 32'h600;
    m0.mem_data_width = 2'b10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (grant !== 1'b1 || mmu.mem_data_width !== 2'b00 || mmu.mem_signed_read !== 1'b1) begin errors++; $display("FAIL ws%0d got g=%0h w=%0h s=%0h exp 1/0/1", i, grant, mmu.mem_data_width, mmu.mem_signed_read); end
    end
    mmu.mem_ready = 1; #1;
    checks++; if (m1.mem_ready !== 1'b1) begin errors++; $display("FAIL ws_done got %0h exp 1", m1.mem_ready); end
    @(negedge clk);
    m1.read_enable = 0; m1.mem_signed_read = 0; mmu.mem_ready = 0;
  endtask
  task automatic test_idle_ready();
    @(negedge clk);
    mmu.mem_ready = 1; mmu.data_out = 32'h99; #1;
    checks++; if (m0.mem_ready !== 1'b0 || m1.mem_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_rdy got %0h/%0h/%0h exp 0/0/0", m0.mem_ready, m1.mem_ready, busy); end
    @(negedge clk);
    mmu.mem_ready = 0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_stay got %0h exp 0", busy); end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_queued_write();
    test_reset_busy();
    test_both_enables();
    test_width_signed();
    test_idle_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
